// File: rtl/fetch_unit.sv
// fetch_unit: Tiny86 instruction fetch stage.
// Owns EIP, prefetches little-endian 32-bit words into a byte-granular buffer
// and presents a 15-byte decode window. A retire either shifts the window by
// instr_len (sequential) or flushes and refetches from next_eip (redirect).
// Optional feature macro: FETCH_FAULT_EN adds the sticky fetch_fault output.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   mem_req, mem_addr             word read request / word-aligned address
//   mem_ack, mem_rdata            read complete / data valid with ack
//   fetch_valid, fetch_bytes, eip decode window (byte 0 at eip in [7:0])
//   retire, instr_len, next_eip   retire handshake from control flow unit
//   fetch_fault                   sticky zero-length retire fault (optional)
module fetch_unit #(
    parameter int unsigned BUF_BYTES = 16,
    parameter logic [31:0] RESET_EIP = 32'h0
) (
    input  logic         clk,
    input  logic         rst_n,
    output logic         mem_req,
    output logic [31:0]  mem_addr,
    input  logic         mem_ack,
    input  logic [31:0]  mem_rdata,
    output logic         fetch_valid,
    output logic [119:0] fetch_bytes,
    output logic [31:0]  eip,
    input  logic         retire,
    input  logic [3:0]   instr_len,
    input  logic [31:0]  next_eip
`ifdef FETCH_FAULT_EN
    ,
    output logic         fetch_fault
`endif
);

    // Three lanes of headroom beyond BUF_BYTES let a word land whenever the
    // window is short of 15 bytes, so a 16-byte buffer can never starve.
    localparam int unsigned WIN = 15;
    localparam int unsigned CAP = BUF_BYTES + 3;
    localparam int unsigned CW  = $clog2(CAP + 1);
    localparam int unsigned LW  = $clog2(CAP);

    typedef enum logic [1:0] {S_FILL, S_WAIT, S_DRAIN} state_t;

    state_t        state_q, state_d;
    logic [7:0]    buf_q [CAP];
    logic [7:0]    buf_d [CAP];
    logic [CW-1:0] count_q, count_d, base;
    logic [31:0]   ptr_q, ptr_d, eip_q, eip_d;
    logic          mem_req_q, fetch_valid_q;
    logic [31:0]   mem_addr_q;
    logic          do_retire, redirect;
    logic [1:0]    lane_off;
    logic [2:0]    n_new;
    logic [3:0]    shift;
    int            idx;

    // Room for another word: either the window is short or a full word fits.
    function automatic logic can_fetch(input logic [CW-1:0] c);
        return (c < CW'(WIN)) || ((32'(c) + 32'd4) <= 32'(BUF_BYTES));
    endfunction

    assign do_retire = retire && fetch_valid_q;
    assign redirect  = do_retire && (next_eip != (eip_q + 32'(instr_len)));
    assign lane_off  = ptr_q[1:0];
    assign n_new     = 3'd4 - {1'b0, lane_off};
    assign shift     = do_retire ? instr_len : 4'd0;

    // Next-state: retire shift, then append at the shifted count.
    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        count_d = count_q;
        ptr_d   = ptr_q;
        eip_d   = eip_q;
        base    = count_q - CW'(shift);
        idx     = 0;
        if (redirect) begin
            count_d = '0;
            eip_d   = next_eip;
            ptr_d   = next_eip;
            state_d = (state_q == S_WAIT && !mem_ack) ? S_DRAIN : S_FILL;
        end else begin
            for (int i = 0; i < int'(CAP); i++) begin
                if (i + int'(shift) < int'(CAP))
                    buf_d[i] = buf_q[LW'(i + int'(shift))];
            end
            if (do_retire) eip_d = next_eip;
            count_d = base;
            case (state_q)
                S_FILL: begin
                    if (can_fetch(count_q)) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        // Misaligned leading lanes belong to earlier bytes.
                        for (int k = 0; k < 4; k++) begin
                            if (k >= int'(lane_off)) begin
                                idx = int'(base) + k - int'(lane_off);
                                if (idx < int'(CAP))
                                    buf_d[LW'(idx)] = mem_rdata[k*8 +: 8];
                            end
                        end
                        count_d = base + CW'(n_new);
                        ptr_d   = ptr_q + 32'(n_new);
                        state_d = can_fetch(base + CW'(n_new)) ? S_WAIT : S_FILL;
                    end
                end
                S_DRAIN: begin
                    if (mem_ack) state_d = S_FILL;
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_FILL;
            count_q       <= '0;
            ptr_q         <= RESET_EIP;
            eip_q         <= RESET_EIP;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= {RESET_EIP[31:2], 2'b00};
            fetch_valid_q <= 1'b0;
            for (int i = 0; i < int'(CAP); i++) buf_q[i] <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            ptr_q         <= ptr_d;
            eip_q         <= eip_d;
            buf_q         <= buf_d;
            mem_req_q     <= (state_d == S_WAIT) || (state_d == S_DRAIN);
            fetch_valid_q <= count_d >= CW'(WIN);
            // Address only moves when (re)entering WAIT; DRAIN holds it.
            if (state_d == S_WAIT) mem_addr_q <= {ptr_d[31:2], 2'b00};
        end
    end

`ifdef FETCH_FAULT_EN
    logic fault_q;

    // Sticky flag for a zero-length retire that would stall forever.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) fault_q <= 1'b0;
        else if (do_retire && instr_len == 4'd0 && next_eip == eip_q) fault_q <= 1'b1;
    end

    assign fetch_fault = fault_q;
`endif

    always_comb begin
        fetch_bytes = '0;
        for (int i = 0; i < int'(WIN); i++) fetch_bytes[i*8 +: 8] = buf_q[i];
    end

    assign mem_req     = mem_req_q;
    assign mem_addr    = mem_addr_q;
    assign fetch_valid = fetch_valid_q;
    assign eip         = eip_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit (BUF_BYTES=20, RESET_EIP=0x100).
// Memory model returns byte value = address[7:0] with a programmable number
// of no-ack cycles before each acknowledge.
module tb_fetch_unit;

    logic         clk;
    logic         rst_n;
    logic         mem_req;
    logic [31:0]  mem_addr;
    logic         mem_ack;
    logic [31:0]  mem_rdata;
    logic         fetch_valid;
    logic [119:0] fetch_bytes;
    logic [31:0]  eip;
    logic         retire;
    logic [3:0]   instr_len;
    logic [31:0]  next_eip;
`ifdef FETCH_FAULT_EN
    logic         fetch_fault;
`endif

    int passed = 0;
    int total  = 0;
    int wait_cycles;
    int wcnt;
    logic [7:0] a0;

    fetch_unit #(.BUF_BYTES(20), .RESET_EIP(32'h100)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .fetch_valid(fetch_valid), .fetch_bytes(fetch_bytes), .eip(eip),
        .retire(retire), .instr_len(instr_len), .next_eip(next_eip)
`ifdef FETCH_FAULT_EN
        , .fetch_fault(fetch_fault)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign a0        = mem_addr[7:0];
    assign mem_ack   = mem_req && (wcnt >= wait_cycles);
    assign mem_rdata = {a0 + 8'd3, a0 + 8'd2, a0 + 8'd1, a0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) wcnt <= 0;
        else if (mem_req && !mem_ack) wcnt <= wcnt + 1;
        else wcnt <= 0;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Window lanes 0..14 must read first, first+1, ...
    task automatic chk_bytes(input string tag, input logic [7:0] first);
        logic [7:0] e;
        for (int i = 0; i < 15; i++) begin
            e = first + 8'(i);
            chk($sformatf("%s[%0d]", tag, i), 32'(fetch_bytes[i*8 +: 8]), 32'(e));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_retire(input logic [3:0] len, input logic [31:0] target);
        retire    = 1'b1;
        instr_len = len;
        next_eip  = target;
        tick();
        retire    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; retire = 1'b0; instr_len = 4'd0; next_eip = 32'h0;
        wait_cycles = 0;
        tick(); tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'h100);
        chk("rst_valid", 32'(fetch_valid), 32'd0);
        chk("rst_eip", eip, 32'h100);
`ifdef FETCH_FAULT_EN
        chk("rst_fault", 32'(fetch_fault), 32'd0);
`endif

        // Zero-wait fill from 0x100.
        rst_n = 1'b1;
        tick(); chk("fill_req1", 32'(mem_req), 32'd1); chk("fill_addr1", mem_addr, 32'h100);
        tick(); chk("fill_addr2", mem_addr, 32'h104);
        tick(); chk("fill_addr3", mem_addr, 32'h108);
        tick(); chk("fill_addr4", mem_addr, 32'h10C); chk("fill_valid4", 32'(fetch_valid), 32'd0);
        tick();
        wait_cycles = 2;
        chk("fill_valid5", 32'(fetch_valid), 32'd1);
        chk_bytes("fill_bytes", 8'h00);
        chk("fill_addr5", mem_addr, 32'h110);

        // Sequential retire while the 0x110 word is still pending.
        do_retire(4'd3, 32'h103);
        chk("seq_eip", eip, 32'h103);
        chk("seq_byte0", 32'(fetch_bytes[7:0]), 32'h03);
        chk("seq_valid_lo", 32'(fetch_valid), 32'd0);
        chk("seq_req", 32'(mem_req), 32'd1);
        chk("seq_addr", mem_addr, 32'h110);
        tick(); chk("seq_valid_lo2", 32'(fetch_valid), 32'd0);
        tick(); chk("seq_valid_hi", 32'(fetch_valid), 32'd1);
        chk_bytes("seq_bytes", 8'h03);
        chk("seq_req_off", 32'(mem_req), 32'd0);

        // Redirect while WAIT is outstanding on 0x114.
        do_retire(4'd2, 32'h105);
        chk("pre_redir_valid", 32'(fetch_valid), 32'd1);
        tick(); chk("pre_redir_addr", mem_addr, 32'h114); chk("pre_redir_req", 32'(mem_req), 32'd1);
        do_retire(4'd1, 32'h202);
        chk("redir_eip", eip, 32'h202);
        chk("redir_valid", 32'(fetch_valid), 32'd0);
        chk("drain_req", 32'(mem_req), 32'd1);
        chk("drain_addr", mem_addr, 32'h114);
        tick(); chk("drain_req2", 32'(mem_req), 32'd1); chk("drain_addr2", mem_addr, 32'h114);
        tick(); chk("drain_done", 32'(mem_req), 32'd0);
        wait_cycles = 0;
        tick(); chk("refill_addr", mem_addr, 32'h200); chk("refill_req", 32'(mem_req), 32'd1);
        tick(); tick(); tick(); tick();
        chk("refill_valid_lo", 32'(fetch_valid), 32'd0);
        tick();
        chk("refill_valid", 32'(fetch_valid), 32'd1);
        chk("refill_eip", eip, 32'h202);
        chk_bytes("refill_bytes", 8'h02);

        // Retire and append in the same cycle at count 15.
        do_retire(4'd3, 32'h205);
        tick(); chk("same_addr", mem_addr, 32'h214); chk("same_req", 32'(mem_req), 32'd1);
        do_retire(4'd4, 32'h209);
        chk("same_valid", 32'(fetch_valid), 32'd1);
        chk("same_eip", eip, 32'h209);
        chk_bytes("same_bytes", 8'h09);
        chk("same_next_addr", mem_addr, 32'h218);

        // Asynchronous reset while a slow request is outstanding.
        tick();
        do_retire(4'd4, 32'h20D);
        wait_cycles = 5;
        tick();
        chk("midwait_req", 32'(mem_req), 32'd1);
        chk("midwait_valid", 32'(fetch_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_valid", 32'(fetch_valid), 32'd0);
        chk("arst_eip", eip, 32'h100);
        chk("arst_addr", mem_addr, 32'h100);
        tick();
        rst_n = 1'b1;
        wait_cycles = 0;
        tick(); chk("restart_req", 32'(mem_req), 32'd1); chk("restart_addr", mem_addr, 32'h100);
        tick(); tick(); tick(); tick();
        chk("restart_valid", 32'(fetch_valid), 32'd1);
        chk_bytes("restart_bytes", 8'h00);

        // Zero-length retire: no-op on the buffer, sticky fault when enabled.
        do_retire(4'd0, 32'h100);
        chk("zlen_eip", eip, 32'h100);
        chk("zlen_byte0", 32'(fetch_bytes[7:0]), 32'h00);
        chk("zlen_valid", 32'(fetch_valid), 32'd1);
`ifdef FETCH_FAULT_EN
        chk("zlen_fault", 32'(fetch_fault), 32'd1);
`endif
        do_retire(4'd1, 32'h101);
        chk("after_zlen_eip", eip, 32'h101);
        chk("after_zlen_byte0", 32'(fetch_bytes[7:0]), 32'h01);
`ifdef FETCH_FAULT_EN
        chk("fault_sticky", 32'(fetch_fault), 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
